// File: rtl/exec_sequencer_pkg.sv
// Shared types for the execution sequencer: FSM state encoding and the
// default no-operation instruction (addi x0, x0, 0).
package exec_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    REPORT  = 2'd2,
    WAIT_TX = 2'd3
  } seq_state_e;

  localparam logic [31:0] NOOP_ADDI = 32'h0000_0013;

endpackage

// File: rtl/exec_sequencer_instr_fifo.sv
// Instruction buffer: power-of-two synchronous FIFO with extra-MSB pointers.
// Push is accepted only when not full before any same-cycle pop.
module instr_fifo #(
  parameter int INST_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic [INST_W-1:0]             data_i,
  input  logic                          pop_i,
  output logic [INST_W-1:0]             data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [INST_W-1:0]  mem_q [FIFO_DEPTH];
  logic               push_ok;
  logic               pop_ok;

  // Same index with differing wrap bits means the writer lapped the reader.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;

  assign push_ok  = push_i && !full_o;
  assign pop_ok   = pop_i && !empty_o;
  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
  assign data_o   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/exec_sequencer.sv
// Buffers received instructions, gates a clk12/2 processor clock around each
// one and requests a regfile dump per batch. EXEC_SEQ_SEND_EACH_EN: dump after every instruction.
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter int                INST_W        = 32,
  parameter int                FIFO_DEPTH    = 4,
  parameter int                RUN_CYCLES    = 10,
  parameter int                INJECT_CYCLES = 3,
  parameter logic [INST_W-1:0] NOOP          = INST_W'(NOOP_ADDI)
) (
  input  logic                        clk12,
  input  logic                        rst,
  input  logic                        inst_in_valid,
  input  logic [INST_W-1:0]           inst_in,
  output logic                        inst_in_ready,
  input  logic                        tx_ready,
  output logic                        clk_proc,
  output logic [INST_W-1:0]           inst_out,
  output logic                        send_regfile,
  output logic                        busy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CW = $clog2(RUN_CYCLES + 1);
`ifdef EXEC_SEQ_SEND_EACH_EN
  localparam bit SEND_EACH = 1'b1;
`else
  localparam bit SEND_EACH = 1'b0;
`endif

  seq_state_e        state_q, state_d;
  logic              div_q;
  logic              run_en_q, run_en_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [INST_W-1:0] cur_inst_q, cur_inst_d;
  logic              tx_low_seen_q, tx_low_seen_d;
  logic              overflow_q;

  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [INST_W-1:0] fifo_data;

  instr_fifo #(
    .INST_W     (INST_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk12),
    .rst     (rst),
    .push_i  (inst_in_valid),
    .data_i  (inst_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk12 or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      div_q         <= 1'b0;
      run_en_q      <= 1'b0;
      cnt_q         <= '0;
      cur_inst_q    <= NOOP;
      tx_low_seen_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= ~div_q;
      run_en_q      <= run_en_d;
      cnt_q         <= cnt_d;
      cur_inst_q    <= cur_inst_d;
      tx_low_seen_q <= tx_low_seen_d;
      if (inst_in_valid && fifo_full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // run_en only moves when div is 0 (about to rise), so clk_proc stays high across it.
  always_comb begin
    state_d       = state_q;
    run_en_d      = run_en_q;
    cnt_d         = cnt_q;
    cur_inst_d    = cur_inst_q;
    tx_low_seen_d = tx_low_seen_q;
    fifo_pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !div_q) begin
          fifo_pop   = 1'b1;
          cur_inst_d = fifo_data;
          cnt_d      = '0;
          run_en_d   = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (cnt_q == CW'(RUN_CYCLES - 1)) begin
          if (SEND_EACH || fifo_empty) begin
            run_en_d = 1'b0;
            state_d  = REPORT;
          end else begin
            fifo_pop   = 1'b1;
            cur_inst_d = fifo_data;
            cnt_d      = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REPORT: begin
        tx_low_seen_d = 1'b0;
        state_d       = WAIT_TX;
      end
      WAIT_TX: begin
        if (!tx_ready) begin
          tx_low_seen_d = 1'b1;
        end else if (tx_low_seen_q) begin
          tx_low_seen_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clk_proc     = run_en_q ? div_q : 1'b1;
    inst_out     = NOOP;
    if ((state_q == RUN) && (cnt_q < CW'(INJECT_CYCLES))) begin
      inst_out = cur_inst_q;
    end
    send_regfile = (state_q == REPORT);
    busy         = (state_q != IDLE) || !fifo_empty;
  end

  assign inst_in_ready = !fifo_full;
  assign overflow      = overflow_q;

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Parametrised execution sequencer for the interactive RISC-V shell. It buffers instructions delivered by the UART receiver in a FIFO and generates the gated processor clock. For each instruction it drives the CPU instruction bus for a configurable window, then noops, and requests a register-file dump from the UART transmitter when a batch completes. It sits between `rx_instruction`, `cpu` and `tx_regfile`, replacing the fixed single-instruction control logic in the top level.

## Interface
- `INST_W`, 32: instruction width.
- `FIFO_DEPTH`, 4: instruction buffer depth; power of two, ≥2.
- `RUN_CYCLES`, 10: `clk12` cycles per instruction; even, ≥4.
- `INJECT_CYCLES`, 3: `clk12` cycles at the start of the run window during which the real instruction is presented; 1..`RUN_CYCLES`.
- `NOOP`, 32'h00000013: value driven on `inst_out` outside the inject window.
- `clk12` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `inst_in_valid` in 1: one-cycle pulse, `inst_in` holds a received instruction.
- `inst_in` in `INST_W`: instruction from the receiver.
- `inst_in_ready` out 1: FIFO not full.
- `tx_ready` in 1: transmitter idle.
- `clk_proc` out 1: gated processor clock, `clk12`/2 while running, held 1 otherwise.
- `inst_out` out `INST_W`: CPU instruction bus.
- `send_regfile` out 1: one-cycle dump request.
- `busy` out 1: state ≠ IDLE or FIFO non-empty.
- `overflow` out 1: sticky, write attempted while full.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: occupancy.

## Operation
- Reset values: `clk_proc`=1, `inst_out`=`NOOP`, `send_regfile`=0, `busy`=0, `inst_in_ready`=1, `overflow`=0, `fifo_count`=0. State is IDLE and `div`=0.
- `div` toggles every `clk12`. `clk_proc` = `run_en ? div : 1`.
- `run_en` changes only on edges where `div` goes 0→1, so `clk_proc` never glitches.
- FIFO push: on `inst_in_valid` when not full. When full, the word is dropped and `overflow` is set until reset. Push and pop in the same cycle are both honoured. Push legality is judged on pre-pop occupancy.
- States:
  - IDLE: when FIFO is non-empty and `div`=0, pop into `cur_inst`, clear `cnt`, set `run_en`, and go to RUN.
  - RUN: `cnt` increments each cycle. `inst_out` = `cur_inst` while `cnt` < `INJECT_CYCLES`, else `NOOP`. At `cnt`=`RUN_CYCLES`-1 (always a `div` 0→1 edge), the instruction completes:
    - If the batch ends (see Configuration), clear `run_en` and go to REPORT.
    - Otherwise pop the next word, reload `cnt`=0, keep `run_en`, and stay in RUN with no gap.
  - REPORT: assert `send_regfile` for one cycle, then go to WAIT_TX.
  - WAIT_TX: wait for `tx_ready`=0, then for `tx_ready`=1, then go to IDLE.
- The regfile snapshot is stable because `clk_proc` is held at 1 from REPORT until the next run.
- A reset asserted mid-run forces all reset values immediately (asynchronous) and empties the FIFO. The in-flight instruction is lost.

## Timing
- Start latency: first run edge 1–2 `clk12` cycles after the word enters the FIFO, depending on `div` phase.
- Each instruction takes exactly `RUN_CYCLES` `clk12` cycles, i.e. `RUN_CYCLES`/2 `clk_proc` rising edges.
- `send_regfile` fires 1 cycle after the last run cycle.
- `inst_in_ready` and `fifo_count` are registered. `inst_in_ready` reflects post-update occupancy on the next cycle.

## Configuration
- `EXEC_SEQ_SEND_EACH_EN` defined: every instruction is its own batch, and a dump is sent after each instruction. This matches the single-step shell behaviour.
- `EXEC_SEQ_SEND_EACH_EN` undefined: a batch ends only when the FIFO is empty at instruction completion, so one dump is sent per drained batch. Words arriving during REPORT or WAIT_TX wait until IDLE.

## Structure
- Shared package `exec_seq_pkg`: state enum (IDLE, RUN, REPORT, WAIT_TX) and the default `NOOP` encoding constant.
- One sub-module: `instr_fifo`, a synchronous FIFO parametrised by `INST_W` and `FIFO_DEPTH`. It provides push/pop, full/empty and count, with pointer wrap on power-of-two depth and an extra MSB for full detection.
- The clock divider, gating and FSM live in `exec_sequencer`.

## Test plan
- Single word 32'h00500093 (addi x1,x0,5), defaults: `inst_out`=32'h00500093 for exactly 3 cycles, then `NOOP` for 7. `clk_proc` shows 5 rising edges, `send_regfile` pulses once, and `clk_proc`=1 afterwards.
- Three back-to-back words, macro undefined: 30 contiguous run cycles, no `clk_proc` high gap >1 cycle, one `send_regfile`. With the macro defined: three pulses, each followed by a WAIT_TX handshake.
- Five pushes with no pops possible (tx stalls with `tx_ready`=0 in WAIT_TX): `fifo_count`=4, `inst_in_ready`=0, fifth word dropped, `overflow`=1 until `rst`.
- Push on the exact cycle of a pop with FIFO full: pop executes, push is dropped, and `fifo_count` goes 4→3.
- `rst` asserted at `cnt`=5: `clk_proc`=1 and `inst_out`=`NOOP` in the same cycle, `fifo_count`=0, and no `send_regfile` after release.
- Glitch check: `clk_proc` high/low widths are always ≥1 `clk12` period across start and stop, for both `div` phases at push time.
